// File: rtl/inst_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: field enums, opcodes,
// FSM states and immediate range helpers.
package inst_encoder_pkg;

  typedef enum logic [3:0] {
    IT_OP     = 4'd0,
    IT_OPIMM  = 4'd1,
    IT_BRANCH = 4'd2,
    IT_LUI    = 4'd3,
    IT_AUIPC  = 4'd4,
    IT_JAL    = 4'd5,
    IT_JALR   = 4'd6,
    IT_LOAD   = 4'd7,
    IT_STORE  = 4'd8,
    IT_NOP    = 4'd9
  } itype_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_NOALU = 4'd10
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NEQ = 3'd1,
    BR_LT  = 3'd2,
    BR_LTU = 3'd3,
    BR_GE  = 3'd4,
    BR_GEU = 3'd5,
    BR_DBR = 3'd6
  } br_func_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_HOLD_HI = 2'd2
  } enc_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // A value fits in N signed bits when every bit from N-1 upward is a copy of the sign.
  function automatic logic fits_s12(input logic [31:0] v);
    return (v[31:11] == '0) || (v[31:11] == '1);
  endfunction

  function automatic logic fits_s13(input logic [31:0] v);
    return (v[31:12] == '0) || (v[31:12] == '1);
  endfunction

  function automatic logic fits_s21(input logic [31:0] v);
    return (v[31:20] == '0) || (v[31:20] == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational fields-to-word packer: builds the RV32I word, flags
// unencodable bundles and detects the LUI+ADDI load-immediate case.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [3:0]  itype,
  input  logic [3:0]  alu_func,
  input  logic [2:0]  br_func,
  input  logic [31:0] imm,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic [31:0] word,
  output logic [31:0] lo_word,
  output logic        expand,
  output logic        err
);

  logic [2:0]  alu_f3;
  logic        alu_ok;
  logic        is_shift;
  logic [2:0]  br_f3;
  logic        br_ok;
  logic [19:0] hi20;

  // Rounding the upper part by imm[11] compensates for ADDI sign-extending lo.
  assign hi20    = imm[31:12] + {19'd0, imm[11]};
  assign lo_word = {imm[11:0], rd, 3'b000, rd, OPC_OPIMM};
  assign is_shift = (alu_func == ALU_SLL) || (alu_func == ALU_SRL) || (alu_func == ALU_SRA);

  // ALU function to funct3, with validity
  always_comb begin
    alu_f3 = 3'b000;
    alu_ok = 1'b1;
    case (alu_func)
      ALU_ADD, ALU_SUB: alu_f3 = 3'b000;
      ALU_SLL:          alu_f3 = 3'b001;
      ALU_SLT:          alu_f3 = 3'b010;
      ALU_SLTU:         alu_f3 = 3'b011;
      ALU_XOR:          alu_f3 = 3'b100;
      ALU_SRL, ALU_SRA: alu_f3 = 3'b101;
      ALU_OR:           alu_f3 = 3'b110;
      ALU_AND:          alu_f3 = 3'b111;
      default:          alu_ok = 1'b0;
    endcase
  end

  // Branch function to funct3, with validity
  always_comb begin
    br_f3 = 3'b000;
    br_ok = 1'b1;
    case (br_func)
      BR_EQ:   br_f3 = 3'b000;
      BR_NEQ:  br_f3 = 3'b001;
      BR_LT:   br_f3 = 3'b100;
      BR_GE:   br_f3 = 3'b101;
      BR_LTU:  br_f3 = 3'b110;
      BR_GEU:  br_f3 = 3'b111;
      default: br_ok = 1'b0;
    endcase
  end

  // Word assembly and range checks per instruction class
  always_comb begin
    word   = NOP_WORD;
    expand = 1'b0;
    err    = 1'b0;
    case (itype)
      IT_OP: begin
        err  = !alu_ok;
        word = {1'b0, (alu_func == ALU_SUB) || (alu_func == ALU_SRA), 5'b0,
                rs2, rs1, alu_f3, rd, OPC_OP};
      end
      IT_OPIMM: begin
        if (!alu_ok || alu_func == ALU_SUB) begin
          err = 1'b1;
        end else if (is_shift) begin
          err  = (imm[31:5] != '0);
          word = {1'b0, alu_func == ALU_SRA, 5'b0, imm[4:0], rs1, alu_f3, rd, OPC_OPIMM};
        end else if (fits_s12(imm)) begin
          word = {imm[11:0], rs1, alu_f3, rd, OPC_OPIMM};
        end else if (alu_func == ALU_ADD && rs1 == 5'd0) begin
          expand = 1'b1;
          word   = {hi20, rd, OPC_LUI};
        end else begin
          err = 1'b1;
        end
      end
      IT_BRANCH: begin
        err  = !br_ok || !fits_s13(imm) || imm[0];
        word = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], OPC_BRANCH};
      end
      IT_LUI: begin
        err  = (imm[11:0] != '0);
        word = {imm[31:12], rd, OPC_LUI};
      end
      IT_AUIPC: begin
        err  = (imm[11:0] != '0);
        word = {imm[31:12], rd, OPC_AUIPC};
      end
      IT_JAL: begin
        err  = !fits_s21(imm) || imm[0];
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      IT_JALR: begin
        err  = !fits_s12(imm);
        word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      end
      IT_LOAD: begin
        err  = !fits_s12(imm);
        word = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      end
      IT_STORE: begin
        err  = !fits_s12(imm);
        word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
      end
      IT_NOP:  word = NOP_WORD;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: accepts field bundles, emits addressed words
// through a one-entry output register, expanding wide load-immediates.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              in_valid_in,
  output logic              in_ready_out,
  input  logic [3:0]        iType_in,
  input  logic [3:0]        aluFunc_in,
  input  logic [2:0]        brFunc_in,
  input  logic [31:0]       imm_in,
  input  logic [4:0]        rs1_in,
  input  logic [4:0]        rs2_in,
  input  logic [4:0]        rd_in,
  output logic              out_valid_out,
  input  logic              out_ready_in,
  output logic [31:0]       word_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              err_out,
  output logic [7:0]        err_count_out
);

  enc_state_e        state, state_nxt;
  logic              accept, drain;
  logic [31:0]       pk_word, pk_lo;
  logic              pk_expand, pk_err;
  logic [31:0]       word_p1, pend_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              err_p1;
  logic [7:0]        err_cnt_p1;

  inst_pack u_pack (
    .itype    (iType_in),
    .alu_func (aluFunc_in),
    .br_func  (brFunc_in),
    .imm      (imm_in),
    .rs1      (rs1_in),
    .rs2      (rs2_in),
    .rd       (rd_in),
    .word     (pk_word),
    .lo_word  (pk_lo),
    .expand   (pk_expand),
    .err      (pk_err)
  );

  assign accept = in_valid_in && in_ready_out;
  assign drain  = out_valid_out && out_ready_in;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state: accepting in HOLD implies the held word drains the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (pk_err)         state_nxt = ST_IDLE;
          else if (pk_expand) state_nxt = ST_HOLD_HI;
          else                state_nxt = ST_HOLD;
        end else if (drain) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD_HI: if (drain) state_nxt = ST_HOLD;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    out_valid_out = (state != ST_IDLE);
    in_ready_out  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready_in);
  end

  // Registered output stage: word, address, error pulse and saturating counter
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      word_p1    <= '0;
      addr_p1    <= BASE_ADDR;
      err_p1     <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      err_p1 <= accept && pk_err;
      if (accept && pk_err && err_cnt_p1 != 8'hFF) err_cnt_p1 <= err_cnt_p1 + 8'd1;
      if (drain) addr_p1 <= addr_p1 + ADDR_W'(4);
      if (accept && !pk_err)                  word_p1 <= pk_word;
      else if (drain && state == ST_HOLD_HI)  word_p1 <= pend_p1;
    end
  end

  // Pending ADDI half of an expansion; only meaningful while in HOLD_HI
  always_ff @(posedge clk_in) begin
    if (accept && pk_expand) pend_p1 <= pk_lo;
  end

  assign word_out      = word_p1;
  assign addr_out      = addr_p1;
  assign err_out       = err_p1;
  assign err_count_out = err_cnt_p1;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: expected words are queued as bundles
// are accepted and popped when the encoder transfers a word.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  itype, alu_func;
  logic [2:0]  br_func;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        out_valid, out_ready;
  logic [31:0] word;
  logic [31:0] addr;
  logic        err;
  logic [7:0]  err_count;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_addr = BASE;
  int          err_model = 0;
  int          err_sent = 0;
  int          err_seen = 0;
  int          stalls = 0;
  logic [31:0] held_addr;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .in_valid_in   (in_valid),
    .in_ready_out  (in_ready),
    .iType_in      (itype),
    .aluFunc_in    (alu_func),
    .brFunc_in     (br_func),
    .imm_in        (imm),
    .rs1_in        (rs1),
    .rs2_in        (rs2),
    .rd_in         (rd),
    .out_valid_out (out_valid),
    .out_ready_in  (out_ready),
    .word_out      (word),
    .addr_out      (addr),
    .err_out       (err),
    .err_count_out (err_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bundle from the next falling edge and wait (bounded) for acceptance.
  // nw: 0 = expect error, 1 = one word, 2 = LUI+ADDI pair.
  task automatic send(input logic [3:0] it, input logic [3:0] af, input logic [2:0] bf,
                      input logic [31:0] im, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rdv, input int nw, input logic [31:0] w1,
                      input logic [31:0] w2);
    int n;
    @(negedge clk);
    itype = it; alu_func = af; br_func = bf; imm = im;
    rs1 = r1; rs2 = r2; rd = rdv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    if (nw == 0) begin
      err_sent++;
      if (err_model != 255) err_model++;
    end else begin
      sb_q.push_back({exp_addr, w1});
      exp_addr += 32'd4;
      if (nw == 2) begin
        sb_q.push_back({exp_addr, w2});
        exp_addr += 32'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (sb_q.size() != 0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("drain_pending", 64'(sb_q.size()), 64'(0));
  endtask

  // Monitor: sample just before each rising edge and score transfers and error pulses
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1) begin
        if (err === 1'b1) err_seen++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_valid", 64'(out_valid), 64'(0));
          end else begin
            e = sb_q.pop_front();
            chk("word", 64'(word), 64'(e[31:0]));
            chk("addr", 64'(addr), 64'(e[63:32]));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    itype = '0; alu_func = '0; br_func = '0; imm = '0; rs1 = '0; rs2 = '0; rd = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_word", 64'(word), 64'(0));
    chk("rst_addr", 64'(addr), 64'(BASE));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Basic OP words at sequential addresses
    send(IT_OP, ALU_ADD, BR_EQ, 32'd0, 5'd1, 5'd2, 5'd3, 1, 32'h002081B3, 32'h0);
    send(IT_OP, ALU_ADD, BR_EQ, 32'd0, 5'd4, 5'd5, 5'd6, 1, 32'h00520333, 32'h0);
    idle();

    // Back-to-back Sub then Branch: no stall expected
    stalls = 0;
    send(IT_OP, ALU_SUB, BR_EQ, 32'd0, 5'd6, 5'd7, 5'd5, 1, 32'h407302B3, 32'h0);
    send(IT_BRANCH, ALU_NOALU, BR_EQ, 32'd8, 5'd1, 5'd2, 5'd0, 1, 32'h00208463, 32'h0);
    chk("b2b_stalls", 64'(stalls), 64'(0));
    idle();

    // Load-immediate expansion; encoder refuses input while ADDI is pending
    send(IT_OPIMM, ALU_ADD, BR_EQ, 32'h12345678, 5'd0, 5'd0, 5'd10, 2, 32'h12345537, 32'h67850513);
    idle();
    #1 chk("hold_hi_in_ready", 64'(in_ready), 64'(0));
    send(IT_OPIMM, ALU_ADD, BR_EQ, 32'h00000800, 5'd0, 5'd0, 5'd1, 2, 32'h000010B7, 32'h80008093);
    idle();
    drain_wait();

    // Unencodable bundles: pulse, count, no word, no address advance
    send(IT_OPIMM, ALU_ADD, BR_EQ, 32'd4096, 5'd1, 5'd0, 5'd2, 0, 32'h0, 32'h0);
    idle();
    #1 chk("err1_pulse", 64'(err), 64'(1));
    chk("err1_no_valid", 64'(out_valid), 64'(0));
    send(IT_BRANCH, ALU_NOALU, BR_EQ, 32'd3, 5'd1, 5'd2, 5'd0, 0, 32'h0, 32'h0);
    idle();
    #1 chk("err2_pulse", 64'(err), 64'(1));
    chk("err2_count", 64'(err_count), 64'(err_model));
    chk("err2_no_valid", 64'(out_valid), 64'(0));
    chk("err_addr_kept", 64'(addr), 64'(exp_addr));
    @(negedge clk);
    #1 chk("err_pulse_ends", 64'(err), 64'(0));

    // Further classes, plus an error accepted while a word is held
    send(IT_LUI, ALU_NOALU, BR_EQ, 32'hABCDE000, 5'd0, 5'd0, 5'd5, 1, 32'hABCDE2B7, 32'h0);
    send(IT_OPIMM, ALU_SUB, BR_EQ, 32'd1, 5'd1, 5'd0, 5'd1, 0, 32'h0, 32'h0);
    send(IT_OPIMM, ALU_SRA, BR_EQ, 32'd4, 5'd2, 5'd0, 5'd3, 1, 32'h40415193, 32'h0);
    send(IT_LOAD, ALU_NOALU, BR_EQ, 32'hFFFFFFFC, 5'd2, 5'd0, 5'd4, 1, 32'hFFC12203, 32'h0);
    send(IT_STORE, ALU_NOALU, BR_EQ, 32'd8, 5'd2, 5'd5, 5'd0, 1, 32'h00512423, 32'h0);
    send(IT_JAL, ALU_NOALU, BR_EQ, 32'd8, 5'd0, 5'd0, 5'd1, 1, 32'h008000EF, 32'h0);
    send(IT_NOP, ALU_NOALU, BR_EQ, 32'd0, 5'd0, 5'd0, 5'd0, 1, 32'h00000013, 32'h0);
    idle();
    drain_wait();
    chk("err3_count", 64'(err_count), 64'(err_model));

    // Back-pressure: held word and address stay put, no new input taken
    out_ready = 1'b0;
    held_addr = exp_addr;
    send(IT_OP, ALU_ADD, BR_EQ, 32'd0, 5'd1, 5'd2, 5'd3, 1, 32'h002081B3, 32'h0);
    idle();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_word", 64'(word), 64'(32'h002081B3));
      chk("stall_addr", 64'(addr), 64'(held_addr));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain_wait();

    // Asynchronous reset while the ADDI half is pending
    out_ready = 1'b0;
    send(IT_OPIMM, ALU_ADD, BR_EQ, 32'h12345678, 5'd0, 5'd0, 5'd10, 2, 32'h12345537, 32'h67850513);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_addr", 64'(addr), 64'(BASE));
    chk("arst_word", 64'(word), 64'(0));
    chk("arst_err_count", 64'(err_count), 64'(0));
    sb_q.delete();
    exp_addr = BASE;
    err_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    send(IT_OP, ALU_ADD, BR_EQ, 32'd0, 5'd1, 5'd2, 5'd3, 1, 32'h002081B3, 32'h0);
    idle();
    drain_wait();

    // Error counter saturation
    for (int i = 0; i < 260; i++)
      send(IT_OPIMM, ALU_SLL, BR_EQ, 32'd32, 5'd1, 5'd0, 5'd1, 0, 32'h0, 32'h0);
    idle();
    #1 chk("err_saturate", 64'(err_count), 64'(err_model));
    drain_wait();
    chk("err_pulse_total", 64'(err_seen), 64'(err_sent));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder: the inverse of the core's decode stage.
- Accepts decoded fields (iType, aluFunc, brFunc, imm, rs1, rs2, rd) over a valid/ready handshake and emits 32-bit instruction words with sequential addresses.
- Used by the program loader and the self-check bench to build instruction memory images from field-level descriptions.
- Expands an out-of-range load-immediate into an LUI+ADDI pair, and flags unencodable requests.

Parameters:
- ADDR_W, 32, width of the emitted word address.
- BASE_ADDR, 32'h0000_0000, address of the first emitted word after reset; must be 4-byte aligned.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- in_valid_in  input  1  field bundle valid.
- in_ready_out  output  1  encoder accepts the bundle this cycle.
- iType_in  input  4  instruction class enum: OP, OPIMM, BRANCH, LUI, AUIPC, JAL, JALR, LOAD, STORE, NOP.
- aluFunc_in  input  4  ALU function enum; used for OP and OPIMM.
- brFunc_in  input  3  branch function enum; used for BRANCH.
- imm_in  input  32  signed immediate, byte offset for B and J.
- rs1_in  input  5  source register 1.
- rs2_in  input  5  source register 2.
- rd_in  input  5  destination register.
- out_valid_out  output  1  word_out and addr_out are valid.
- out_ready_in  input  1  sink accepts the word.
- word_out  output  32  encoded instruction word.
- addr_out  output  ADDR_W  address of word_out.
- err_out  output  1  one-cycle pulse: the accepted bundle was unencodable.
- err_count_out  output  8  saturating count of rejected bundles.

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - state=IDLE; out_valid_out=0; word_out=0; addr_out=BASE_ADDR.
  - err_out=0; err_count_out=0; in_ready_out=1 once reset is released.
  - Reset mid-operation discards any held or pending word.
- Handshakes:
  - An input transfer occurs when in_valid_in && in_ready_out.
  - An output transfer occurs when out_valid_out && out_ready_in.
  - Output word, address and valid stay stable until transferred.
- States:
  - IDLE: output register empty.
  - HOLD: one word held.
  - HOLD_HI: LUI held, ADDI pending.
- in_ready_out = (state==IDLE) || (state==HOLD && out_ready_in). This gives full throughput for single-word instructions.
- Latency: the word appears on out_valid_out in the cycle after acceptance (registered output).
- Encoding rules:
  - Standard RV32I opcodes.
  - OP: Sub and Sra set funct7=0x20; all other OP functions set funct7=0.
  - OPIMM:
    - Sll, Srl and Sra use imm[4:0] as shamt; Sra sets bit30.
    - imm[31:5] of a shift must be 0, otherwise error.
  - LOAD/STORE: funct3=3'b010 (LW/SW).
  - JALR: funct3=0.
  - NOP: emits 32'h0000_0013.
- Range checks (violation → error):
  - I-type and S-type imm: signed 12-bit.
  - B imm: signed 13-bit and even.
  - J imm: signed 21-bit and even.
  - LUI/AUIPC: imm[11:0] must be 0.
  - Enum values outside their lists are also errors (e.g. NoAlu on OP, Dbr on BRANCH, aluFunc=Sub on OPIMM).
- Load-immediate expansion:
  - Applies to OPIMM Add with rs1=0 and imm outside the signed 12-bit range.
  - hi = (imm + 32'h800) >> 12 (logical shift); lo = imm[11:0].
  - First word: LUI rd, hi. Second word: ADDI rd, rd, lo.
  - Sequence IDLE→HOLD_HI→HOLD; in_ready_out=0 while in HOLD_HI.
  - rd=0 still expands; no special case.
  - OPIMM Add out of range with rs1≠0 is an error.
- Errors:
  - The bundle is consumed: no word is emitted and the address does not advance.
  - err_out pulses in the cycle after acceptance.
  - err_count_out saturates at 255.
  - An error accepted while in HOLD leaves the held word unaffected.
- Addressing: addr_out advances by 4 on every output transfer and wraps modulo 2^ADDR_W.
- Simultaneous drain and accept in HOLD:
  - A new single word loads directly into HOLD.
  - A new expansion moves to HOLD_HI.
  - A new error moves to IDLE.

Decomposition:
- Enums (iType, aluFunc, brFunc), opcode constants and the NOP word constant live in the existing shared types.svh.
- Natural sub-module: inst_pack, a combinational fields→word packer with a range-check/error output and an expand flag.
- inst_encoder holds the FSM, the output register, the address counter and the error counter.

Test Plan:
- OP Add rs1=1 rs2=2 rd=3 → word 0x002081B3 at addr 0x0; next word at addr 0x4.
- OP Sub rs1=6 rs2=7 rd=5, then BRANCH Eq rs1=1 rs2=2 imm=8, back-to-back with out_ready_in=1 → 0x407302B3 then 0x00208463 on consecutive cycles, in_ready_out never low.
- OPIMM Add rs1=0 rd=10 imm=0x12345678 → 0x12345537 then 0x67850513 at consecutive addresses; in_ready_out=0 in HOLD_HI.
- OPIMM Add rs1=0 rd=1 imm=0x800 → 0x000010B7 then 0x80008093 (exercises the negative-lo adjust).
- OPIMM Add rs1=1 imm=4096, and BRANCH imm=3 → err_out pulses twice, err_count_out=2, no out_valid_out, address unchanged.
- Hold out_ready_in=0 for 5 cycles with a word held → word and address stable, in_ready_out=0. Assert rst_n_in=0 during HOLD_HI → out_valid_out=0 immediately, addr_out=BASE_ADDR, ADDI is never emitted.
